dmem_be: RTL and testbench

Byte-addressable RV32I data memory for the pipeline MEM stage, the successor to the word-only data RAM. It executes all RV32I load/store sizes (SB/SH/SW, LB/LH/LW/LBU/LHU) with byte-lane writes and sign/zero extension. It has a registered one-cycle read, a request/response handshake, and fault reporting for misaligned, out-of-range or illegal accesses. An optional post-reset clear sweep holds `ready` low until the array is zeroed.

---
 rtl/dmem_be.sv | 169 ++++++++++++++++
 tb/tb_dmem_be.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_be.sv
// dmem_be: byte-addressable RV32I data memory with registered read and faults.
// Optional post-reset clear sweep enabled by defining DMEM_CLEAR_EN.
`timescale 1ns/1ps
module dmem_be #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        w_en,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] w_d,
  output logic        ready,
  output logic        r_valid,
  output logic [31:0] r_d,
  output logic        fault
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {S_CLEAR, S_RUN} state_e;

  state_e state_q, state_d;

`ifdef DMEM_CLEAR_EN
  logic [AW-1:0] cnt_q, cnt_d;
  logic [31:0]   mem_q [DEPTH];
`else
  logic [31:0]   mem_q [DEPTH] = '{default: '0};
`endif

  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          oor, bad, flt, acc, do_wr;
  logic [3:0]    be;
  logic [31:0]   wdata, mask;

  logic          valid_q, fault_q, ld_q;
  logic [31:0]   word_q;
  logic [2:0]    f3_q;
  logic [1:0]    lane_q;
  logic [7:0]    byte_s;
  logic [15:0]   half_s;
  logic [31:0]   ext;

  assign idx   = addr[AW+1:2];
  assign lane  = addr[1:0];
  assign ready = (state_q == S_RUN);

  // request decode: fault classification, byte enables, lane-replicated data
  always_comb begin
    oor   = |addr[31:AW+2];
    bad   = 1'b0;
    be    = 4'b1111;
    wdata = w_d;
    unique case (funct3)
      3'b000, 3'b100: bad = 1'b0;
      3'b001, 3'b101: bad = addr[0];
      3'b010:         bad = |lane;
      default:        bad = 1'b1;
    endcase
    unique case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << lane;
        wdata = {4{w_d[7:0]}};
      end
      2'b01: begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{w_d[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = w_d;
      end
    endcase
    flt   = oor | bad | (w_en & funct3[2]);
    acc   = req & ready & ~rst;
    do_wr = acc & w_en & ~flt;
    mask  = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  end

  // next state: sweep the array once after reset, then run
  always_comb begin
    state_d = state_q;
`ifdef DMEM_CLEAR_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      S_CLEAR: begin
`ifdef DMEM_CLEAR_EN
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH - 1)) state_d = S_RUN;
`else
        state_d = S_RUN;
`endif
      end
      default: state_d = S_RUN;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CLEAR;
`ifdef DMEM_CLEAR_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef DMEM_CLEAR_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // array write: sweep zeroes or lane-masked store
  always_ff @(posedge clk) begin
`ifdef DMEM_CLEAR_EN
    if (state_q == S_CLEAR && !rst) begin
      mem_q[cnt_q] <= '0;
    end else if (do_wr) begin
      mem_q[idx] <= (mem_q[idx] & ~mask) | (wdata & mask);
    end
`else
    if (do_wr) begin
      mem_q[idx] <= (mem_q[idx] & ~mask) | (wdata & mask);
    end
`endif
  end

  // response register: one-cycle pulse per accepted request
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      ld_q    <= 1'b0;
      word_q  <= '0;
      f3_q    <= '0;
      lane_q  <= '0;
    end else begin
      valid_q <= acc;
      fault_q <= acc & flt;
      ld_q    <= acc & ~w_en & ~flt;
      if (acc) begin
        word_q <= mem_q[idx];
        f3_q   <= funct3;
        lane_q <= lane;
      end
    end
  end

  // load extraction and extension from the registered word
  always_comb begin
    byte_s = word_q[{lane_q, 3'b000} +: 8];
    half_s = lane_q[1] ? word_q[31:16] : word_q[15:0];
    unique case (f3_q)
      3'b000:  ext = {{24{byte_s[7]}}, byte_s};
      3'b100:  ext = {24'h0, byte_s};
      3'b001:  ext = {{16{half_s[15]}}, half_s};
      3'b101:  ext = {16'h0, half_s};
      default: ext = word_q;
    endcase
  end

  assign r_valid = valid_q;
  assign fault   = fault_q;
  assign r_d     = ld_q ? ext : 32'h0;

endmodule

// File: tb/tb_dmem_be.sv
// tb_dmem_be: directed test of dmem_be against a byte-array model.
// Expectations follow DMEM_CLEAR_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_dmem_be;
  localparam int DEPTH = 256;
`ifdef DMEM_CLEAR_EN
  localparam int CLR_N = DEPTH;
  localparam logic [31:0] KEEP40 = 32'h0;
`else
  localparam int CLR_N = 1;
  localparam logic [31:0] KEEP40 = 32'h5;
`endif

  logic        clk = 0;
  logic        rst = 1;
  logic        req = 0;
  logic        w_en = 0;
  logic [2:0]  funct3 = 0;
  logic [31:0] addr = 0;
  logic [31:0] w_d = 0;
  logic        ready, r_valid, fault;
  logic [31:0] r_d;

  int total = 0;
  int bad = 0;

  dmem_be #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req(req), .w_en(w_en),
    .funct3(funct3), .addr(addr), .w_d(w_d),
    .ready(ready), .r_valid(r_valid), .r_d(r_d), .fault(fault)
  );

  always #5 clk = ~clk;

  logic [7:0]  mm [4*DEPTH];
  logic        live = 0;
  logic        m_ready = 0;
  int          rel = 0;
  logic        e_valid = 0;
  logic        e_fault = 0;
  logic [31:0] e_rd = 0;

  initial for (int i = 0; i < 4*DEPTH; i++) mm[i] = 8'h0;

  function automatic logic [31:0] m_load(int unsigned a, logic [2:0] f);
    logic [31:0] r;
    case (f)
      3'b000:  r = {{24{mm[a][7]}}, mm[a]};
      3'b100:  r = {24'h0, mm[a]};
      3'b001:  r = {{16{mm[a+1][7]}}, mm[a+1], mm[a]};
      3'b101:  r = {16'h0, mm[a+1], mm[a]};
      default: r = {mm[a+3], mm[a+2], mm[a+1], mm[a]};
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    int unsigned a;
    logic acc, flt;
    live = 1;
    if (rst) begin
      m_ready = 0; rel = 0;
      e_valid = 0; e_fault = 0; e_rd = 0;
`ifdef DMEM_CLEAR_EN
      for (int i = 0; i < 4*DEPTH; i++) mm[i] = 8'h0;
`endif
    end else begin
      a = addr;
      acc = req && m_ready;
      e_valid = acc; e_fault = 0; e_rd = 0;
      if (acc) begin
        flt = (a >= 4*DEPTH) || (funct3 == 3) || (funct3 >= 6)
           || (w_en && funct3 >= 4)
           || ((funct3 == 1 || funct3 == 5) && (a % 2 != 0))
           || (funct3 == 2 && (a % 4 != 0));
        e_fault = flt;
        if (!flt && w_en) begin
          mm[a] = w_d[7:0];
          if (funct3 != 0) mm[a+1] = w_d[15:8];
          if (funct3 == 2) begin
            mm[a+2] = w_d[23:16];
            mm[a+3] = w_d[31:24];
          end
        end else if (!flt) begin
          e_rd = m_load(a, funct3);
        end
      end
      rel++;
      if (rel >= CLR_N) m_ready = 1;
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (live) begin
      chk("ready", {31'h0, ready}, {31'h0, m_ready});
      chk("r_valid", {31'h0, r_valid}, {31'h0, e_valid});
      chk("fault", {31'h0, fault}, {31'h0, e_fault});
      chk("r_d", r_d, e_rd);
    end
  end

  task automatic issue(logic w, logic [2:0] f, logic [31:0] a, logic [31:0] d);
    req = 1; w_en = w; funct3 = f; addr = a; w_d = d;
    @(posedge clk); #1;
    req = 0;
  endtask

  task automatic ld(string nm, logic [2:0] f, logic [31:0] a, logic [31:0] exp);
    issue(0, f, a, 0);
    chk({nm, "_v"}, {31'h0, r_valid}, 32'h1);
    chk(nm, r_d, exp);
  endtask

  task automatic flt_chk(string nm, logic w, logic [2:0] f, logic [31:0] a);
    issue(w, f, a, 32'hFFFF_FFFF);
    chk({nm, "_f"}, {31'h0, fault}, 32'h1);
    chk(nm, r_d, 32'h0);
  endtask

  task automatic do_reset(output int n);
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ready && n < 400);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    req = 1; w_en = 0; funct3 = 3'b010; addr = 0;
    n = 0;
    do begin
      @(posedge clk); #1;
      req = 0;
      n++;
      if (n == 1) chk("clr_noresp", {31'h0, r_valid}, 32'h0);
    end while (!ready && n < 400);
    chk("clr_len", n, CLR_N);
    ld("lw0", 3'b010, 32'h000, 32'h0);

    issue(1, 3'b010, 32'h010, 32'h1122_3344);
    issue(1, 3'b000, 32'h011, 32'h0000_00AB);
    ld("lw10", 3'b010, 32'h010, 32'h1122_AB44);
    ld("lb11", 3'b000, 32'h011, 32'hFFFF_FFAB);
    ld("lbu11", 3'b100, 32'h011, 32'h0000_00AB);

    issue(1, 3'b001, 32'h022, 32'h0000_8001);
    ld("lh22", 3'b001, 32'h022, 32'hFFFF_8001);
    ld("lhu22", 3'b101, 32'h022, 32'h0000_8001);
    ld("lw20", 3'b010, 32'h020, 32'h8001_0000);

    flt_chk("lh13", 0, 3'b001, 32'h013);
    flt_chk("sw12", 1, 3'b010, 32'h012);
    flt_chk("lw400", 0, 3'b010, 32'h400);
    flt_chk("f3_011", 0, 3'b011, 32'h010);
    flt_chk("st100", 1, 3'b100, 32'h010);
    ld("keep10", 3'b010, 32'h010, 32'h1122_AB44);

    issue(1, 3'b010, 32'h030, 32'hDEAD_BEEF);
    chk("b2b_sv", {31'h0, r_valid}, 32'h1);
    chk("b2b_sd", r_d, 32'h0);
    ld("b2b_lw", 3'b010, 32'h030, 32'hDEAD_BEEF);

    req = 1; w_en = 0; funct3 = 3'b010; addr = 32'h030; rst = 1;
    @(posedge clk); #1;
    req = 0;
    chk("rst_drop", {31'h0, r_valid}, 32'h0);
    do_reset(n);
    chk("rst1_len", n, CLR_N);

    issue(1, 3'b010, 32'h040, 32'h5);
    do_reset(n);
    chk("rst2_len", n, CLR_N);
    ld("lw40", 3'b010, 32'h040, KEEP40);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
